// File: rtl/axi_llc_flush_seq.sv
// Way-flush sequencer: expands a way mask into single-set Flush requests to the
// LLC tag store, one outstanding at a time, and tracks flushed ways and evictions.
module axi_llc_flush_seq #(
  parameter int unsigned NumWays    = 8,
  parameter int unsigned NumLines   = 256,
  parameter int unsigned IndexWidth = $clog2(NumLines),
  parameter int unsigned CntWidth   = 16
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic [NumWays-1:0]    cmd_ways_i,
  input  logic                  cmd_valid_i,
  output logic                  cmd_ready_o,
  output logic                  st_valid_o,
  input  logic                  st_ready_i,
  output logic [NumWays-1:0]    st_way_o,
  output logic [IndexWidth-1:0] st_index_o,
  input  logic                  res_valid_i,
  output logic                  res_ready_o,
  input  logic                  res_evict_i,
  output logic                  busy_o,
  output logic                  done_o,
  output logic [NumWays-1:0]    flushed_o,
  output logic [CntWidth-1:0]   evict_cnt_o
);

  typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_e;

  localparam logic [IndexWidth-1:0] LastIndex = IndexWidth'(NumLines - 1);

  state_e                  state_q, state_d;
  logic [NumWays-1:0]      pending_q, pending_d;
  logic [NumWays-1:0]      way_q, way_d;
  logic [NumWays-1:0]      flushed_q, flushed_d;
  logic [IndexWidth-1:0]   index_q, index_d;
  logic [CntWidth-1:0]     cnt_q, cnt_d;
  logic [NumWays-1:0]      pend_left;

  // Isolates the lowest set bit as a one-hot vector (two's-complement trick).
  function automatic logic [NumWays-1:0] lowest(input logic [NumWays-1:0] m);
    return m & (~m + NumWays'(1));
  endfunction

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= IDLE;
      pending_q <= '0;
      way_q     <= '0;
      flushed_q <= '0;
      index_q   <= '0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      pending_q <= pending_d;
      way_q     <= way_d;
      flushed_q <= flushed_d;
      index_q   <= index_d;
      cnt_q     <= cnt_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    pending_d   = pending_q;
    way_d       = way_q;
    flushed_d   = flushed_q;
    index_d     = index_q;
    cnt_d       = cnt_q;
    cmd_ready_o = 1'b0;
    st_valid_o  = 1'b0;
    st_way_o    = '0;
    res_ready_o = 1'b0;
    busy_o      = 1'b1;
    done_o      = 1'b0;
    pend_left   = pending_q & ~way_q;

    unique case (state_q)
      IDLE: begin
        cmd_ready_o = 1'b1;
        busy_o      = 1'b0;
        if (cmd_valid_i) begin
          pending_d = cmd_ways_i;
          flushed_d = flushed_q & ~cmd_ways_i;
          cnt_d     = '0;
          index_d   = '0;
          if (|cmd_ways_i) begin
            way_d   = lowest(cmd_ways_i);
            state_d = REQ;
          end else begin
            state_d = DONE;
          end
        end
      end
      REQ: begin
        st_valid_o = 1'b1;
        st_way_o   = way_q;
        if (st_ready_i) state_d = WAIT;
      end
      WAIT: begin
        res_ready_o = 1'b1;
        if (res_valid_i) begin
          if (res_evict_i && (cnt_q != '1)) cnt_d = cnt_q + CntWidth'(1);
          if (index_q != LastIndex) begin
            index_d = index_q + IndexWidth'(1);
            state_d = REQ;
          end else begin
            flushed_d = flushed_q | way_q;
            pending_d = pend_left;
            index_d   = '0;
            if (|pend_left) begin
              way_d   = lowest(pend_left);
              state_d = REQ;
            end else begin
              state_d = DONE;
            end
          end
        end
      end
      DONE: begin
        done_o  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign st_index_o  = index_q;
  assign flushed_o   = flushed_q;
  assign evict_cnt_o = cnt_q;

  a_way_onehot0: assert property (@(posedge clk_i) disable iff (!rst_ni)
    $onehot0(st_way_o));
  a_req_stable: assert property (@(posedge clk_i) disable iff (!rst_ni)
    (st_valid_o && !st_ready_i) |=> (st_valid_o && $stable(st_way_o) && $stable(st_index_o)));
  a_no_res_idle: assert property (@(posedge clk_i) disable iff (!rst_ni)
    (state_q == IDLE) |-> !res_valid_i);

endmodule

// File: tb/tb_axi_llc_flush_seq.sv
// Directed bench for axi_llc_flush_seq: table of flush commands with expected
// request streams and final state, plus hand-written reset-abort sequence.
module tb_axi_llc_flush_seq;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] cmd_ways;
  logic       cmd_valid;
  logic       cmd_ready;
  logic       st_valid;
  logic       st_ready;
  logic [3:0] st_way;
  logic [2:0] st_index;
  logic       res_valid;
  logic       res_ready;
  logic       res_evict;
  logic       busy;
  logic       done;
  logic [3:0] flushed;
  logic [2:0] evict_cnt;

  int passed = 0;
  int total  = 0;

  always #5 clk = ~clk;

  // The tag store answers every response cycle while a flush is running.
  assign res_valid = busy;

  axi_llc_flush_seq #(
    .NumWays (4),
    .NumLines(8),
    .CntWidth(3)
  ) dut (
    .clk_i      (clk),
    .rst_ni     (rst_n),
    .cmd_ways_i (cmd_ways),
    .cmd_valid_i(cmd_valid),
    .cmd_ready_o(cmd_ready),
    .st_valid_o (st_valid),
    .st_ready_i (st_ready),
    .st_way_o   (st_way),
    .st_index_o (st_index),
    .res_valid_i(res_valid),
    .res_ready_o(res_ready),
    .res_evict_i(res_evict),
    .busy_o     (busy),
    .done_o     (done),
    .flushed_o  (flushed),
    .evict_cnt_o(evict_cnt)
  );

  typedef struct {
    logic [3:0] ways;
    logic       evict;
    int         stall_idx;
    int         stall_len;
    logic [3:0] exp_flushed;
    logic [2:0] exp_cnt;
  } vec_t;

  vec_t vecs[5];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic run_cmd(input logic [3:0] ways, input logic evict, input int stall_idx,
                         input int stall_len, input logic [3:0] exp_flushed,
                         input logic [2:0] exp_cnt);
    int sel[4];
    int nsel = 0;
    int k = 0;
    int stalls = 0;
    int dones = 0;
    int reqs;
    int cycles = 0;
    logic [3:0] exp_way;
    logic [2:0] exp_idx;
    for (int w = 0; w < 4; w++) if (ways[w]) begin sel[nsel] = w; nsel++; end
    reqs = nsel * 8;

    chk("cmd_ready_idle", 32'(cmd_ready), 32'(1));
    cmd_ways  = ways;
    cmd_valid = 1'b1;
    res_evict = evict;
    st_ready  = 1'b1;
    cyc();
    cmd_valid = 1'b0;
    chk("evict_cleared", 32'(evict_cnt), 32'(0));
    chk("first_valid", 32'(st_valid), 32'(nsel != 0));

    while (dones == 0 && cycles < 1000) begin
      if (done) begin
        dones++;
      end else begin
        if (st_valid) begin
          if (k >= reqs) begin
            chk("extra_req", 32'(k), 32'(reqs));
          end else begin
            exp_way = 4'(1 << sel[k / 8]);
            exp_idx = 3'(k % 8);
            chk("req", 32'({st_way, st_index}), 32'({exp_way, exp_idx}));
          end
          if ((k % 8) == stall_idx && stalls < stall_len) begin
            st_ready = 1'b0;
            stalls++;
          end else begin
            st_ready = 1'b1;
            k++;
          end
        end
        cyc();
        cycles++;
      end
    end

    chk("done_seen", 32'(dones), 32'(1));
    chk("req_count", 32'(k), 32'(reqs));
    chk("stall_cycles", 32'(stalls), 32'((stall_idx >= 0 && nsel > 0) ? stall_len : 0));
    chk("flushed", 32'(flushed), 32'(exp_flushed));
    chk("evict_cnt", 32'(evict_cnt), 32'(exp_cnt));
    chk("busy_in_done", 32'(busy), 32'(1));
    cyc();
    chk("done_one_cycle", 32'(done), 32'(0));
    chk("back_to_idle", 32'(cmd_ready), 32'(1));
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_cmd_ready"}, 32'(cmd_ready), 32'(1));
    chk({tag, "_st_valid"},  32'(st_valid),  32'(0));
    chk({tag, "_st_way"},    32'(st_way),    32'(0));
    chk({tag, "_st_index"},  32'(st_index),  32'(0));
    chk({tag, "_res_ready"}, 32'(res_ready), 32'(0));
    chk({tag, "_busy"},      32'(busy),      32'(0));
    chk({tag, "_done"},      32'(done),      32'(0));
    chk({tag, "_flushed"},   32'(flushed),   32'(0));
    chk({tag, "_evict_cnt"}, 32'(evict_cnt), 32'(0));
  endtask

  initial begin
    int hs;
    int cycles;
    vecs[0] = '{4'b0101, 1'b0, -1, 0, 4'b0101, 3'd0};
    vecs[1] = '{4'b0000, 1'b0, -1, 0, 4'b0101, 3'd0};
    vecs[2] = '{4'b1000, 1'b0,  3, 5, 4'b1101, 3'd0};
    vecs[3] = '{4'b0001, 1'b1, -1, 0, 4'b1101, 3'd7};
    vecs[4] = '{4'b0010, 1'b0, -1, 0, 4'b1111, 3'd0};

    rst_n     = 1'b0;
    cmd_ways  = '0;
    cmd_valid = 1'b0;
    st_ready  = 1'b0;
    res_evict = 1'b0;
    cyc();
    chk_reset_outputs("por");
    #2 rst_n = 1'b1;
    cyc();

    for (int v = 0; v < 5; v++)
      run_cmd(vecs[v].ways, vecs[v].evict, vecs[v].stall_idx, vecs[v].stall_len,
              vecs[v].exp_flushed, vecs[v].exp_cnt);

    // Abort a two-way flush after four responses.
    cmd_ways  = 4'b0011;
    cmd_valid = 1'b1;
    res_evict = 1'b1;
    st_ready  = 1'b1;
    cyc();
    cmd_valid = 1'b0;
    hs = 0;
    cycles = 0;
    while (hs < 4 && cycles < 100) begin
      if (res_ready) hs++;
      cyc();
      cycles++;
    end
    chk("abort_responses", 32'(hs), 32'(4));
    chk("abort_cnt_before", 32'(evict_cnt), 32'(4));
    #2 rst_n = 1'b0;
    #1 chk_reset_outputs("abort");
    #2 rst_n = 1'b1;
    cyc();
    chk_reset_outputs("release");

    run_cmd(4'b0001, 1'b1, -1, 0, 4'b0001, 3'd7);
    run_cmd(4'b0010, 1'b0, -1, 0, 4'b0011, 3'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
